lsu: RTL and testbench
======================

Name: lsu

Overview:
- CPU-side load/store unit: the initiator that drives the memory request interface answered by the MMU.
- Accepts one decoded load/store from the memory stage and computes the effective address.
- Checks alignment and funct3 legality, then issues a single request pulse to the MMU and waits for mem_ready.
- Returns sign/zero-extended load data with the destination register, and stalls the pipeline via busy while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT without mem_ready before a bus-timeout fault (1..65535)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
op_valid  input  1  memory-stage op present; sampled only when busy=0
op_is_store  input  1  1 = store, 0 = load
op_funct3  input  3  RV32I load/store funct3
op_base  input  32  rs1 value
op_offset  input  32  sign-extended immediate
op_store_data  input  32  rs2 value, low bits used for SB/SH
op_rd  input  5  load destination register
busy  output  1  high while state != IDLE; pipeline holds the op
result_valid  output  1  one-cycle pulse, transaction complete
result_we  output  1  with result_valid: 1 for loads, 0 for stores
result_rd  output  5  captured op_rd
result_data  output  32  extended load data; 0 for stores
fault_valid  output  1  one-cycle pulse, no result_valid in the same op
fault_cause  output  2  1 misaligned, 2 illegal funct3, 3 timeout
fault_addr  output  32  effective address of the faulting op
mem_read_enable  output  1  MMU read request
mem_write_enable  output  1  MMU write request
mem_signed_read  output  1  funct3[2]==0 for loads, 0 for stores
mem_data_width  output  2  0 byte, 1 half, 3 word (MMU_WIDTH_WORD)
mem_address  output  32  effective address
mem_data_out  output  32  store data to MMU data_in
mem_data_in  input  32  MMU data_out, already extended by the MMU
mem_ready  input  1  MMU completion pulse

Behaviour:
- Reset (async, immediate): state IDLE; every output 0, including mem enables, busy, result_*, fault_*, mem_address, and mem_data_out.
- Effective address: op_base + op_offset, modulo 2^32; wrap is not a fault.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Width mapping: funct3[1:0] 00 -> 0, 01 -> 1, 10 -> 3.
- Misaligned: half with ea[0]=1; word with ea[1:0] != 0. Illegal is checked before misaligned.
- States: IDLE, REQ, WAIT.
- IDLE, op_valid=1 at an edge:
  - Illegal or misaligned op: fault_valid=1 next cycle with cause and fault_addr=ea. State stays IDLE, busy stays 0, no MMU request issued.
  - Legal op: capture ea, width, signed, store data and rd; go to REQ.
- REQ (exactly one cycle): busy=1; mem_read_enable = !is_store; mem_write_enable = is_store. Then go to WAIT and clear the timeout counter.
- WAIT: both enables 0.
  - mem_address, mem_data_out, mem_data_width and mem_signed_read are held stable from REQ through the edge where mem_ready is sampled. The MMU reads these combinationally and in later states.
  - mem_ready=1: capture mem_data_in (loads) and go to IDLE. The next cycle has result_valid=1, result_we=!is_store, result_rd, and result_data (0 for stores).
  - Counter reaches TIMEOUT_CYCLES without mem_ready: go to IDLE; fault_valid=1, cause 3, next cycle.
- The enables are never high for more than one cycle per op, so the MMU cannot re-trigger from IDLE.
- mem_ready seen in IDLE or REQ is ignored.
- op_valid while busy=1 is ignored; no queueing.
- A new op may be accepted in the same cycle that result_valid/fault_valid pulses (back-to-back throughput).
- Load data passes through unchanged: the MMU performs sign extension.
- Store data goes out as op_store_data; the MMU merges bytes by width.
- Reset mid-transaction: abandon immediately, no result or fault pulse.

Test Plan:
- LW ea=0x00000010 (base 0x8 + offset 0x8), MMU returns 0xDEADBEEF -> one-cycle read pulse, width 3, address held until mem_ready; result_valid with result_data=0xDEADBEEF, rd=5, busy high until completion.
- LB then LBU at 0x01000003, memory byte 0x80 -> mem_signed_read 1 then 0; results 0xFFFFFF80 then 0x00000080.
- SB 0xAB at 0x01000001, then LW 0x01000000 (prior 0x11223344) -> write pulse width 0, result_we=0; subsequent LW returns 0x1122AB44.
- LH at 0x01000001, and SW at 0x01000002 -> fault_valid cause 1, fault_addr matches, no enable ever asserted, busy stays 0.
- Load funct3=011 and store funct3=100 -> cause 2, no MMU request. Base 0xFFFFFFFC + offset 8 -> ea 0x00000004, no fault.
- TIMEOUT_CYCLES=4, MMU never responds -> cause 3 after 4 WAIT cycles. A second run asserts reset_n=0 during WAIT: outputs clear asynchronously, no pulse, and the next op is accepted normally.

Source files
------------

// File: rtl/lsu.sv
// CPU-side load/store unit: computes the effective address, checks legality and alignment,
// issues one request pulse to the MMU and returns extended load data or a fault.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic        op_is_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_base,
  input  logic [31:0] op_offset,
  input  logic [31:0] op_store_data,
  input  logic [4:0]  op_rd,
  output logic        busy,
  output logic        result_valid,
  output logic        result_we,
  output logic [4:0]  result_rd,
  output logic [31:0] result_data,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        mem_signed_read,
  output logic [1:0]  mem_data_width,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt;
  logic        is_store_q;
  logic [4:0]  rd_q;
  logic [31:0] ea;
  logic        illegal, misaligned, timeout_hit;
  logic [1:0]  width;

  assign ea          = op_base + op_offset;
  assign timeout_hit = (wait_cnt == LAST_CNT);

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    width      = 2'd0;
    if (op_is_store)
      illegal = op_funct3[2] || (op_funct3[1:0] == 2'b11);
    else
      illegal = (op_funct3 == 3'b011) || (op_funct3[2:1] == 2'b11);
    case (op_funct3[1:0])
      2'b00:   width = 2'd0;
      2'b01:   width = 2'd1;
      default: width = 2'd3;
    endcase
    misaligned = ((op_funct3[1:0] == 2'b01) && ea[0]) ||
                 ((op_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_valid && !illegal && !misaligned) state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (mem_ready || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt        <= '0;
      is_store_q      <= 1'b0;
      rd_q            <= '0;
      result_valid    <= 1'b0;
      result_we       <= 1'b0;
      result_rd       <= '0;
      result_data     <= '0;
      fault_valid     <= 1'b0;
      fault_cause     <= '0;
      fault_addr      <= '0;
      mem_signed_read <= 1'b0;
      mem_data_width  <= '0;
      mem_address     <= '0;
      mem_data_out    <= '0;
    end else begin
      result_valid <= 1'b0;
      fault_valid  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            if (illegal || misaligned) begin
              fault_valid <= 1'b1;
              fault_cause <= illegal ? 2'd2 : 2'd1;
              fault_addr  <= ea;
            end else begin
              mem_address     <= ea;
              mem_data_width  <= width;
              mem_signed_read <= !op_is_store && !op_funct3[2];
              mem_data_out    <= op_store_data;
              is_store_q      <= op_is_store;
              rd_q            <= op_rd;
            end
          end
        end
        S_REQ: wait_cnt <= '0;
        S_WAIT: begin
          // mem_ready wins over timeout when both land on the same edge
          if (mem_ready) begin
            result_valid <= 1'b1;
            result_we    <= !is_store_q;
            result_rd    <= rd_q;
            result_data  <= is_store_q ? '0 : mem_data_in;
          end else if (timeout_hit) begin
            fault_valid <= 1'b1;
            fault_cause <= 2'd3;
            fault_addr  <= mem_address;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign mem_read_enable  = (state_q == S_REQ) && !is_store_q;
  assign mem_write_enable = (state_q == S_REQ) && is_store_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a byte-addressed MMU model answers requests and a
// reference model predicts faults, request fields, results and timeouts.
module tb_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid, op_is_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_base, op_offset, op_store_data;
  logic [4:0]  op_rd;
  logic        busy, result_valid, result_we;
  logic [4:0]  result_rd;
  logic [31:0] result_data;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic        mem_read_enable, mem_write_enable, mem_signed_read;
  logic [1:0]  mem_data_width;
  logic [31:0] mem_address, mem_data_out, mem_data_in;
  logic        mem_ready;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .op_valid(op_valid), .op_is_store(op_is_store), .op_funct3(op_funct3),
    .op_base(op_base), .op_offset(op_offset), .op_store_data(op_store_data), .op_rd(op_rd),
    .busy(busy), .result_valid(result_valid), .result_we(result_we),
    .result_rd(result_rd), .result_data(result_data),
    .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_signed_read(mem_signed_read), .mem_data_width(mem_data_width),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [int unsigned];

  function automatic logic [7:0] rb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] w);
    return (w == 2'd3) ? 4 : int'(w) + 1;
  endfunction

  // Loads as the MMU delivers them: little-endian, already extended
  function automatic logic [31:0] mmu_load(input logic [31:0] a, input logic [1:0] w, input logic sgn);
    logic [31:0] v = '0;
    int unsigned n = nbytes(w);
    for (int unsigned i = 0; i < n; i++) v = v | (32'(rb(a + i)) << (8 * i));
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mmu_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    for (int unsigned i = 0; i < nbytes(w); i++) mem[a + i] = d[8*i +: 8];
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] d);
    mmu_store(a, 2'd3, d);
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge carrying the
  // result/fault pulse so the next op can be launched back-to-back.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] sdata, input logic [4:0] rd,
                       input int lat, output logic [31:0] rdata);
    logic [31:0] ea = base + off;
    int unsigned size = 1 << f3[1:0];
    bit legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bit mis = legal && ((ea % size) != 0);
    logic [1:0] wcode = (size == 4) ? 2'd3 : 2'(size - 1);
    logic [31:0] exp_load = '0;
    int unsigned en_cnt;
    bit stable = 1'b1;
    bit done = 1'b0;
    rdata = '0;
    op_valid = 1'b1; op_is_store = st; op_funct3 = f3;
    op_base = base; op_offset = off; op_store_data = sdata; op_rd = rd;
    @(negedge clk);
    op_valid = 1'b0;
    if (!legal || mis) begin
      check("fault_valid", 32'(fault_valid), 1);
      check("fault_cause", 32'(fault_cause), legal ? 1 : 2);
      check("fault_addr", fault_addr, ea);
      check("fault_busy", 32'(busy), 0);
      check("fault_noreq", {30'd0, mem_read_enable, mem_write_enable}, 0);
      check("fault_noresult", 32'(result_valid), 0);
      return;
    end
    check("req_busy", 32'(busy), 1);
    check("req_rd_en", 32'(mem_read_enable), 32'(!st));
    check("req_wr_en", 32'(mem_write_enable), 32'(st));
    check("req_addr", mem_address, ea);
    check("req_width", 32'(mem_data_width), 32'(wcode));
    check("req_signed", 32'(mem_signed_read), st ? 0 : 32'(!f3[2]));
    if (st) check("req_wdata", mem_data_out, sdata);
    check("req_no_pulse", {30'd0, result_valid, fault_valid}, 0);
    en_cnt = 32'(mem_read_enable) + 32'(mem_write_enable);
    for (int w = 0; w < int'(TO) && !done; w++) begin
      @(negedge clk);
      en_cnt += 32'(mem_read_enable) + 32'(mem_write_enable);
      if (mem_address !== ea || mem_data_width !== wcode || !busy ||
          (st && mem_data_out !== sdata)) stable = 1'b0;
      // ops presented while busy must be ignored
      op_valid = 1'($urandom_range(0, 1));
      op_is_store = 1'($urandom_range(0, 1));
      op_funct3 = 3'd2; op_base = $urandom; op_offset = 32'd0; op_rd = 5'($urandom);
      if (w == lat) begin
        mem_ready = 1'b1;
        if (mem_write_enable === 1'b0 && mem_read_enable === 1'b0 && st) begin
          mmu_store(mem_address, mem_data_width, mem_data_out);
          mem_data_in = $urandom;
        end else begin
          mem_data_in = mmu_load(mem_address, mem_data_width, mem_signed_read);
          exp_load = mmu_load(ea, wcode, !f3[2]);
        end
        done = 1'b1;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    op_valid = 1'b0;
    check("req_once", en_cnt, 1);
    check("req_hold", 32'(stable), 1);
    check("done_busy", 32'(busy), 0);
    if (done) begin
      check("res_valid", 32'(result_valid), 1);
      check("res_we", 32'(result_we), 32'(!st));
      check("res_rd", 32'(result_rd), 32'(rd));
      check("res_data", result_data, st ? 32'd0 : exp_load);
      check("res_nofault", 32'(fault_valid), 0);
      rdata = result_data;
    end else begin
      check("to_valid", 32'(fault_valid), 1);
      check("to_cause", 32'(fault_cause), 3);
      check("to_addr", fault_addr, ea);
      check("to_noresult", 32'(result_valid), 0);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      mem_ready = 1'b0;
      check("idle_ignore", {29'd0, busy, result_valid, fault_valid}, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {20'd0, busy, result_valid, result_we, fault_valid, mem_read_enable,
                mem_write_enable, mem_signed_read, mem_data_width, fault_cause, 1'b0}, 0);
    check({tag, "_rd"}, 32'(result_rd), 0);
    check({tag, "_data"}, result_data | fault_addr | mem_address | mem_data_out, 0);
  endtask

  logic [31:0] r;

  initial begin
    reset_n = 1'b0; op_valid = 1'b0; op_is_store = 1'b0; op_funct3 = '0;
    op_base = '0; op_offset = '0; op_store_data = '0; op_rd = '0;
    mem_data_in = '0; mem_ready = 1'b0;
    for (int unsigned a = 32'h0100_0000; a < 32'h0100_0050; a++) mem[a] = 8'($urandom);
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    set_word(32'h10, 32'hDEAD_BEEF);
    do_op(0, 3'b010, 32'h8, 32'h8, 0, 5'd5, 1, r);
    check("lw_data", r, 32'hDEAD_BEEF);

    mem[32'h0100_0003] = 8'h80;
    do_op(0, 3'b000, 32'h0100_0000, 32'h3, 0, 5'd7, 0, r);
    check("lb_data", r, 32'hFFFF_FF80);
    do_op(0, 3'b100, 32'h0100_0000, 32'h3, 0, 5'd8, 2, r);
    check("lbu_data", r, 32'h0000_0080);

    set_word(32'h0100_0000, 32'h1122_3344);
    do_op(1, 3'b000, 32'h0100_0000, 32'h1, 32'h5555_55AB, 5'd3, 1, r);
    do_op(0, 3'b010, 32'h0100_0000, 32'h0, 0, 5'd9, 3, r);
    check("sb_lw_data", r, 32'h1122_AB44);

    do_op(0, 3'b001, 32'h0100_0000, 32'h1, 0, 5'd1, 0, r);
    do_op(1, 3'b010, 32'h0100_0000, 32'h2, 32'h1234, 5'd1, 0, r);
    do_op(0, 3'b011, 32'h0100_0000, 32'h0, 0, 5'd1, 0, r);
    do_op(1, 3'b100, 32'h0100_0000, 32'h0, 0, 5'd1, 0, r);

    set_word(32'h4, 32'hCAFE_F00D);
    do_op(0, 3'b010, 32'hFFFF_FFFC, 32'h8, 0, 5'd10, 0, r);
    check("wrap_data", r, 32'hCAFE_F00D);

    do_op(0, 3'b010, 32'h0100_0010, 32'h0, 0, 5'd11, -1, r);
    idle_gap(2);

    // reset while waiting for the MMU
    op_valid = 1'b1; op_is_store = 1'b0; op_funct3 = 3'b010;
    op_base = 32'h0100_0020; op_offset = 32'h0; op_rd = 5'd12;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    idle_gap(3);
    do_op(1, 3'b001, 32'h0100_0020, 32'h4, 32'hBEEF, 5'd13, 0, r);
    do_op(0, 3'b101, 32'h0100_0020, 32'h4, 0, 5'd14, 1, r);
    check("after_reset_lhu", r, 32'h0000_BEEF);

    for (int i = 0; i < 200; i++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'h0100_0000 + 32'($urandom_range(0, 60)), 32'($urandom_range(0, 8)) - 32'd4,
            $urandom, 5'($urandom), $urandom_range(0, 5), r);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
